// File: rtl/sram_port_pkg.sv
// rtl/sram_port_pkg.sv - shared types and parameter-legality helpers for the SRAM port driver
package sram_port_pkg;

  // Which requester wins the next contended cycle.
  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } prio_e;

  // Each mask bit must cover a whole, equal-sized slice of the data word.
  function automatic bit mask_w_legal(input int data_w, input int mask_w);
    return (mask_w > 0) && ((data_w % mask_w) == 0);
  endfunction

  // Two entries are the minimum that lets reads stream at one per cycle.
  function automatic bit resp_depth_legal(input int depth);
    return depth >= 2;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - register-based read-response queue
module sram_resp_fifo #(
  parameter int DATA_W     = 20,
  parameter int RESP_DEPTH = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push,
  input  logic [DATA_W-1:0]                   din,
  input  logic                                pop,
  output logic [DATA_W-1:0]                   dout,
  output logic [$clog2(RESP_DEPTH+1)-1:0]     count,
  output logic                                empty
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy; a pop on an empty queue is ignored.
  always_comb begin
    pop_ok   = pop & (count_q != '0);
    wr_ptr_d = push   ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_ok);
  end

  // Pointer and occupancy registers; reset flushes the queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset: an entry is only visible after it was written.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // The credit scheme upstream must keep occupancy within the queue size.
  always @(posedge clock) begin
    if (!reset) assert (count_q <= CNT_W'(RESP_DEPTH));
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_rw_port_driver.sv
// rtl/sram_rw_port_driver.sv - arbitrates write/read requests onto a 1-cycle-latency masked SRAM RW port
module sram_rw_port_driver
  import sram_port_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 20,
  parameter int MASK_W     = 10,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADDR_W-1:0] wreq_addr,
  input  logic [MASK_W-1:0] wreq_mask,
  input  logic [DATA_W-1:0] wreq_data,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADDR_W-1:0] rreq_addr,
  output logic              rresp_valid,
  input  logic              rresp_ready,
  output logic [DATA_W-1:0] rresp_data,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  if (!mask_w_legal(DATA_W, MASK_W)) begin : g_bad_mask
    $error("MASK_W must divide DATA_W");
  end
  if (!resp_depth_legal(RESP_DEPTH)) begin : g_bad_depth
    $error("RESP_DEPTH must be at least 2");
  end

  prio_e            prio_q, prio_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic [CNT_W:0]   credit_use;
  logic             pop, rd_ok, contend, grant_w, grant_r;

  // Credit check, arbitration and next-state for prio/inflight.
  always_comb begin
    pop        = ~q_empty & rresp_ready;
    credit_use = {1'b0, q_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    rd_ok      = credit_use < (CNT_W + 1)'(RESP_DEPTH);
    contend    = wreq_valid & rreq_valid & rd_ok;
    grant_w    = ~reset & wreq_valid & ~(contend & (prio_q == READ_FIRST));
    grant_r    = ~reset & rreq_valid & rd_ok & ~grant_w;
    inflight_d = grant_r;
    prio_d     = prio_q;
    if (contend) prio_d = (prio_q == WRITE_FIRST) ? READ_FIRST : WRITE_FIRST;
  end

  // Drive the macro from whichever request won; zeros when idle so its read register holds.
  always_comb begin
    RW0_en    = grant_w | grant_r;
    RW0_wmode = grant_w;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (grant_w) begin
      RW0_addr  = wreq_addr;
      RW0_wmask = wreq_mask;
      RW0_wdata = wreq_data;
    end else if (grant_r) begin
      RW0_addr  = rreq_addr;
    end
  end

  // Round-robin priority and the one-deep in-flight read marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q     <= WRITE_FIRST;
      inflight_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
    end
  end

  sram_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .din   (RW0_rdata),
    .pop   (pop),
    .dout  (rresp_data),
    .count (q_count),
    .empty (q_empty)
  );

  assign wreq_ready  = grant_w;
  assign rreq_ready  = grant_r;
  assign rresp_valid = ~q_empty;

endmodule

// File: tb/tb_sram_rw_port_driver.sv
// tb/tb_sram_rw_port_driver.sv - directed self-checking bench for sram_rw_port_driver
module tb_sram_rw_port_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        wreq_valid, wreq_ready;
  logic [9:0]  wreq_addr, wreq_mask;
  logic [19:0] wreq_data;
  logic        rreq_valid, rreq_ready;
  logic [9:0]  rreq_addr;
  logic        rresp_valid, rresp_ready;
  logic [19:0] rresp_data;
  logic [9:0]  RW0_addr;
  logic        RW0_en, RW0_wmode;
  logic [9:0]  RW0_wmask;
  logic [19:0] RW0_wdata;
  logic [19:0] RW0_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  sram_rw_port_driver dut (
    .clock       (clock),
    .reset       (reset),
    .wreq_valid  (wreq_valid),
    .wreq_ready  (wreq_ready),
    .wreq_addr   (wreq_addr),
    .wreq_mask   (wreq_mask),
    .wreq_data   (wreq_data),
    .rreq_valid  (rreq_valid),
    .rreq_ready  (rreq_ready),
    .rreq_addr   (rreq_addr),
    .rresp_valid (rresp_valid),
    .rresp_ready (rresp_ready),
    .rresp_data  (rresp_data),
    .RW0_addr    (RW0_addr),
    .RW0_en      (RW0_en),
    .RW0_wmode   (RW0_wmode),
    .RW0_wmask   (RW0_wmask),
    .RW0_wdata   (RW0_wdata),
    .RW0_rdata   (RW0_rdata)
  );

  // Behavioural masked SRAM macro, 2 data bits per mask bit, 1-cycle read latency.
  logic [19:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    RW0_rdata = '0;
  end
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int g = 0; g < 10; g++)
          if (RW0_wmask[g]) mem[RW0_addr][g*2 +: 2] <= RW0_wdata[g*2 +: 2];
      end else begin
        RW0_rdata <= mem[RW0_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [9:0] m, input logic [19:0] d);
    int k = 0;
    wreq_valid = 1'b1; wreq_addr = a; wreq_mask = m; wreq_data = d;
    @(negedge clock);
    while (!wreq_ready && k < 8) begin tick(); @(negedge clock); k++; end
    if (!wreq_ready) begin n_cmp++; n_bad++; $display("FAIL write_timeout addr=%h got ready=0 exp=1", a); end
    tick();
    wreq_valid = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a);
    int k = 0;
    rreq_valid = 1'b1; rreq_addr = a;
    @(negedge clock);
    while (!rreq_ready && k < 8) begin tick(); @(negedge clock); k++; end
    if (!rreq_ready) begin n_cmp++; n_bad++; $display("FAIL read_timeout addr=%h got ready=0 exp=1", a); end
    tick();
    rreq_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [19:0] d);
    bit got = 0;
    d = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clock);
      if (rresp_valid) begin d = rresp_data; got = 1; end
      tick();
    end
    if (!got) begin n_cmp++; n_bad++; $display("FAIL resp_timeout got no rresp_valid exp=1"); end
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wreq_valid = 1'b1; wreq_addr = 10'h155; wreq_mask = 10'h3FF; wreq_data = 20'h12345;
    rreq_valid = 1'b1; rreq_addr = 10'h0AA; rresp_ready = 1'b1;
    tick(); tick();
    @(negedge clock);
    n_cmp++; if (wreq_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wready got=%b exp=0", wreq_ready); end
    n_cmp++; if (rreq_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rready got=%b exp=0", rreq_ready); end
    n_cmp++; if (rresp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got=%b exp=0", rresp_valid); end
    n_cmp++; if (rresp_data !== 20'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", rresp_data); end
    n_cmp++; if (RW0_en !== 1'b0 || RW0_wmode !== 1'b0) begin n_bad++; $display("FAIL rst_en got en=%b wm=%b exp=0", RW0_en, RW0_wmode); end
    n_cmp++; if (RW0_addr !== 10'h0 || RW0_wmask !== 10'h0 || RW0_wdata !== 20'h0) begin
      n_bad++; $display("FAIL rst_cmd got addr=%h mask=%h data=%h exp=0", RW0_addr, RW0_wmask, RW0_wdata); end
    tick();
    wreq_valid = 1'b0; rreq_valid = 1'b0; wreq_addr = '0; wreq_mask = '0; wreq_data = '0; rreq_addr = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wreq_valid = 1'b1; wreq_addr = 10'h005; wreq_mask = 10'h3FF; wreq_data = 20'hABCDE;
    @(negedge clock);
    n_cmp++; if (wreq_ready !== 1'b1) begin n_bad++; $display("FAIL t1_wready got=%b exp=1", wreq_ready); end
    n_cmp++; if (RW0_en !== 1'b1 || RW0_wmode !== 1'b1) begin n_bad++; $display("FAIL t1_wcmd got en=%b wm=%b exp=1/1", RW0_en, RW0_wmode); end
    n_cmp++; if (RW0_addr !== 10'h005 || RW0_wmask !== 10'h3FF || RW0_wdata !== 20'hABCDE) begin
      n_bad++; $display("FAIL t1_wpass got addr=%h mask=%h data=%h exp=005/3ff/abcde", RW0_addr, RW0_wmask, RW0_wdata); end
    tick();
    wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 10'h005; rresp_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (rreq_ready !== 1'b1) begin n_bad++; $display("FAIL t1_rready got=%b exp=1", rreq_ready); end
    n_cmp++; if (RW0_en !== 1'b1 || RW0_wmode !== 1'b0 || RW0_wmask !== 10'h0 || RW0_wdata !== 20'h0 || RW0_addr !== 10'h005) begin
      n_bad++; $display("FAIL t1_rcmd got en=%b wm=%b mask=%h data=%h addr=%h exp=1/0/0/0/005", RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, RW0_addr); end
    tick();
    rreq_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_lat1 got rvalid=%b exp=0", rresp_valid); end
    n_cmp++; if (RW0_en !== 1'b0 || RW0_addr !== 10'h0) begin n_bad++; $display("FAIL t1_idle got en=%b addr=%h exp=0/0", RW0_en, RW0_addr); end
    tick();
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b1 || rresp_data !== 20'hABCDE) begin
      n_bad++; $display("FAIL t1_lat2 got rvalid=%b data=%h exp=1/abcde", rresp_valid, rresp_data); end
    tick();
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_popped got rvalid=%b exp=0", rresp_valid); end
    tick();
  endtask

  task automatic test_mask();
    logic [19:0] d;
    rresp_ready = 1'b1;
    do_write(10'h010, 10'h3FF, 20'hFFFFF);
    do_write(10'h010, 10'h001, 20'h00000);
    do_read(10'h010);
    wait_resp(d);
    n_cmp++; if (d !== 20'hFFFFC) begin n_bad++; $display("FAIL t2_partial got=%h exp=ffffc", d); end
    wreq_valid = 1'b1; wreq_addr = 10'h010; wreq_mask = 10'h000; wreq_data = 20'h00000;
    @(negedge clock);
    n_cmp++; if (wreq_ready !== 1'b1 || RW0_en !== 1'b1 || RW0_wmode !== 1'b1 || RW0_wmask !== 10'h0) begin
      n_bad++; $display("FAIL t2_mask0_issue got rdy=%b en=%b wm=%b mask=%h exp=1/1/1/0", wreq_ready, RW0_en, RW0_wmode, RW0_wmask); end
    tick();
    wreq_valid = 1'b0;
    do_read(10'h010);
    wait_resp(d);
    n_cmp++; if (d !== 20'hFFFFC) begin n_bad++; $display("FAIL t2_mask0_noop got=%h exp=ffffc", d); end
  endtask

  task automatic test_round_robin();
    logic exp_w;
    pulse_reset();
    rresp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_w = ((c % 2) == 0);
      wreq_valid = 1'b1; wreq_addr = 10'h030; wreq_mask = 10'h3FF; wreq_data = 20'h03000 + 20'(c);
      rreq_valid = 1'b1; rreq_addr = 10'h031;
      @(negedge clock);
      n_cmp++; if (wreq_ready !== exp_w || rreq_ready !== !exp_w) begin
        n_bad++; $display("FAIL t3_grant c=%0d got w=%b r=%b exp w=%b r=%b", c, wreq_ready, rreq_ready, exp_w, !exp_w); end
      n_cmp++; if (RW0_en !== 1'b1 || RW0_wmode !== exp_w) begin
        n_bad++; $display("FAIL t3_cmd c=%0d got en=%b wm=%b exp en=1 wm=%b", c, RW0_en, RW0_wmode, exp_w); end
      tick();
    end
    wreq_valid = 1'b0; rreq_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    for (int i = 0; i < 4; i++) do_write(10'h040 + 10'(i), 10'h3FF, 20'h40040 + 20'(i * 17));
    rresp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rreq_valid = 1'b1; rreq_addr = 10'h040 + 10'(acc);
      @(negedge clock);
      if (rreq_ready) acc++;
      if (c == 5) begin
        n_cmp++; if (rreq_ready !== 1'b0) begin n_bad++; $display("FAIL t4_blocked got rready=%b exp=0", rreq_ready); end
      end
      tick();
    end
    rreq_valid = 1'b0;
    n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL t4_accepted got=%0d exp=2", acc); end
    rresp_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b1 || rresp_data !== 20'h40040) begin
      n_bad++; $display("FAIL t4_first got v=%b data=%h exp=1/40040", rresp_valid, rresp_data); end
    tick();
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b1 || rresp_data !== 20'h40051) begin
      n_bad++; $display("FAIL t4_second got v=%b data=%h exp=1/40051", rresp_valid, rresp_data); end
    tick();
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b0) begin n_bad++; $display("FAIL t4_drained got v=%b exp=0", rresp_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_d;
    rresp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      rreq_valid = (c < 4); rreq_addr = 10'h040 + 10'(c % 4);
      @(negedge clock);
      if (c < 4) begin
        n_cmp++; if (rreq_ready !== 1'b1) begin n_bad++; $display("FAIL t_b2b_ready c=%0d got=%b exp=1", c, rreq_ready); end
      end
      if (c >= 2 && c < 6) begin
        exp_d = 20'h40040 + 20'((c - 2) * 17);
        n_cmp++; if (rresp_valid !== 1'b1 || rresp_data !== exp_d) begin
          n_bad++; $display("FAIL t_b2b_data c=%0d got v=%b data=%h exp=1/%h", c, rresp_valid, rresp_data, exp_d); end
      end
      tick();
    end
    rreq_valid = 1'b0;
  endtask

  task automatic test_hazard();
    logic [19:0] d;
    rresp_ready = 1'b1;
    do_write(10'h020, 10'h3FF, 20'h0AAAA);
    rreq_valid = 1'b1; rreq_addr = 10'h020;
    @(negedge clock);
    n_cmp++; if (rreq_ready !== 1'b1) begin n_bad++; $display("FAIL t5_rready got=%b exp=1", rreq_ready); end
    tick();
    rreq_valid = 1'b0;
    wreq_valid = 1'b1; wreq_addr = 10'h020; wreq_mask = 10'h3FF; wreq_data = 20'h12345;
    @(negedge clock);
    n_cmp++; if (wreq_ready !== 1'b1) begin n_bad++; $display("FAIL t5_wready got=%b exp=1", wreq_ready); end
    tick();
    wreq_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b1 || rresp_data !== 20'h0AAAA) begin
      n_bad++; $display("FAIL t5_old got v=%b data=%h exp=1/0aaaa", rresp_valid, rresp_data); end
    tick();
    do_read(10'h020);
    wait_resp(d);
    n_cmp++; if (d !== 20'h12345) begin n_bad++; $display("FAIL t5_new got=%h exp=12345", d); end
  endtask

  task automatic test_reset_midop();
    logic [19:0] d;
    rresp_ready = 1'b1;
    do_write(10'h050, 10'h3FF, 20'h5A5A5);
    do_read(10'h050);
    reset = 1'b1;
    rreq_valid = 1'b1; rreq_addr = 10'h050;
    @(negedge clock);
    n_cmp++; if (rresp_valid !== 1'b0 || rresp_data !== 20'h0 || rreq_ready !== 1'b0 || wreq_ready !== 1'b0) begin
      n_bad++; $display("FAIL t6_rst_outs got v=%b data=%h rr=%b wr=%b exp=0", rresp_valid, rresp_data, rreq_ready, wreq_ready); end
    n_cmp++; if (RW0_en !== 1'b0 || RW0_addr !== 10'h0) begin
      n_bad++; $display("FAIL t6_rst_cmd got en=%b addr=%h exp=0/0", RW0_en, RW0_addr); end
    tick();
    reset = 1'b0; rreq_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_cmp++; if (rresp_valid !== 1'b0) begin n_bad++; $display("FAIL t6_no_resp c=%0d got=%b exp=0", c, rresp_valid); end
      tick();
    end
    do_read(10'h050);
    wait_resp(d);
    n_cmp++; if (d !== 20'h5A5A5) begin n_bad++; $display("FAIL t6_after got=%h exp=5a5a5", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_hazard();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
